multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Multicycle MIPS control unit. Supersedes the single-cycle main decoder.
//  A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles.
//  Memory accesses use a req/ready handshake so variable-latency memory stalls the sequence.
//  Sits between the instruction register (opcode in) and the shared datapath muxes/enables (out).
// PARAMETERS
//  OP_W      6          opcode width
//  OP_RTYPE  6'b000000  R-type opcode
//  OP_LW     6'b100011  load-word opcode
//  OP_SW     6'b100001  store opcode (team encoding)
//  OP_BEQ    6'b000100  branch-on-equal opcode
//  OP_ADDI   6'b001000  add-immediate opcode
//  OP_J      6'b000010  jump opcode
// PORTS
//  clk          in   1     clock, rising edge
//  reset_n      in   1     asynchronous active-low reset
//  instruc      in   OP_W  opcode from IR; stable from DECODE until next FETCH
//  zero         in   1     ALU zero flag
//  mem_ready    in   1     memory completes the current access this cycle
//  mem_req      out  1     memory access request
//  mem_write    out  1     memory write strobe
//  lor_d        out  1     address select: 0=PC, 1=ALUOut
//  ir_write     out  1     IR load enable
//  pc_write     out  1     unconditional PC write
//  branch       out  1     branch evaluation active
//  pc_en        out  1     pc_write | (branch & take); take is zero (BEQ) or ~zero (BNE)
//  pc_src       out  2     00=ALU result, 01=ALUOut, 10=jump target
//  alu_src_a    out  1     0=PC, 1=reg A
//  alu_src_b    out  2     00=reg B, 01=const 4, 10=sign-ext imm, 11=imm<<2
//  alu_instruc  out  2     00=add, 01=sub, 10=funct decode
//  reg_write    out  1     register file write enable
//  reg_dst      out  1     0=rt, 1=rd
//  mem_reg      out  1     writeback select: 1=memory data, 0=ALUOut
//  illegal_op   out  1     one-cycle pulse in DECODE on an unrecognised opcode
//  state_o      out  4     current state encoding, for debug
// BEHAVIOUR
//  - Reset: state=FETCH. While reset_n=0 every output is 0; state_o reports FETCH.
//  - Outputs are combinational from the state register (plus mem_ready/zero where noted).
//  - Unlisted outputs are 0 in every state.
//  - States, outputs and transitions:
//    FETCH:   mem_req=1, src_b=01, ir_write=pc_write=mem_ready. ->DECODE if mem_ready, else hold.
//    DECODE:  src_b=11. LW/SW->MEMADR, RTYPE->RTYPEEX, BEQ->BEQEX, ADDI->ADDIEX, J->JEX.
//             Any other opcode: illegal_op=1, ->FETCH.
//    MEMADR:  src_a=1, src_b=10. ->MEMRD for LW, ->MEMWR for SW.
//    MEMRD:   mem_req=1, lor_d=1. ->MEMWB if mem_ready, else hold.
//    MEMWB:   reg_write=1, mem_reg=1. ->FETCH.
//    MEMWR:   mem_req=1, mem_write=1, lor_d=1, held until mem_ready. ->FETCH on mem_ready.
//    RTYPEEX: src_a=1, alu_instruc=10. ->RTYPEWB.
//    RTYPEWB: reg_write=1, reg_dst=1. ->FETCH.
//    BEQEX:   src_a=1, alu_instruc=01, branch=1, pc_src=01. ->FETCH.
//    ADDIEX:  src_a=1, src_b=10. ->ADDIWB.
//    ADDIWB:  reg_write=1. ->FETCH.
//    JEX:     pc_src=10, pc_write=1. ->FETCH.
//  - Latency at zero wait states (mem_ready=1 throughout): LW 5 cycles; SW and R-type 4;
//    ADDI 4; BEQ 3; J 3.
//  - Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs stay constant.
//  - mem_ready is ignored in every other state.
//  - reset_n asserted mid-instruction aborts it asynchronously; no write strobe survives reset.
//  - Unused state encodings recover to FETCH on the next clock with all outputs 0.
// CONFIGURATION
//  MCTRL_BNE_EN defined:
//    - adds opcode 6'b000101 (BNE): DECODE ->BNEEX.
//    - BNEEX has the same outputs as BEQEX; pc_en = ~zero.
//  MCTRL_BNE_EN undefined:
//    - 6'b000101 is illegal: illegal_op pulse, ->FETCH.
//    - BNEEX encoding does not exist.
// TESTING
//  1. reset_n=0 mid-MEMWR -> all outputs 0 immediately; after release state_o=FETCH, mem_req=1.
//  2. LW, mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMRD,MEMWB; reg_write=1 only in cycle 5.
//  3. SW, mem_ready low 3 cycles in MEMWR -> mem_write high 4 cycles, then FETCH.
//  4. BEQ with zero=1 then zero=0 -> pc_en=1 in BEQEX only for zero=1; pc_src=01; 3 cycles each.
//  5. Opcode 6'b111111 -> illegal_op pulse 1 cycle, FETCH next, no reg_write/mem_write.
//  6. Opcode 6'b000101, zero=0:
//     with MCTRL_BNE_EN -> pc_en=1 in BNEEX;
//     without it -> illegal_op=1, then FETCH.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, stalling on a req/ready memory handshake.
// Optional BNE support is compiled in when MCTRL_BNE_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned    OP_W     = 6,
  parameter logic [OP_W-1:0] OP_RTYPE = 6'b000000,
  parameter logic [OP_W-1:0] OP_LW    = 6'b100011,
  parameter logic [OP_W-1:0] OP_SW    = 6'b100001,
  parameter logic [OP_W-1:0] OP_BEQ   = 6'b000100,
  parameter logic [OP_W-1:0] OP_ADDI  = 6'b001000,
  parameter logic [OP_W-1:0] OP_J     = 6'b000010
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [OP_W-1:0] instruc,
  input  logic            zero,
  input  logic            mem_ready,
  output logic            mem_req,
  output logic            mem_write,
  output logic            lor_d,
  output logic            ir_write,
  output logic            pc_write,
  output logic            branch,
  output logic            pc_en,
  output logic [1:0]      pc_src,
  output logic            alu_src_a,
  output logic [1:0]      alu_src_b,
  output logic [1:0]      alu_instruc,
  output logic            reg_write,
  output logic            reg_dst,
  output logic            mem_reg,
  output logic            illegal_op,
  output logic [3:0]      state_o
);

  localparam int unsigned STATE_W = 4;

`ifdef MCTRL_BNE_EN
  localparam logic [OP_W-1:0] OP_BNE = OP_W'(6'b000101);
`endif

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
`ifdef MCTRL_BNE_EN
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12
`else
    S_JEX     = 4'd11
`endif
  } state_e;

  state_e state_q, state_d;

  // Pre-reset-gating decoded controls
  logic       mem_req_c, mem_write_c, lor_d_c, ir_write_c, pc_write_c;
  logic       branch_c, take_c, alu_src_a_c, reg_write_c, reg_dst_c;
  logic       mem_reg_c, illegal_op_c;
  logic [1:0] pc_src_c, alu_src_b_c, alu_instruc_c;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode from the current state
  always_comb begin
    state_d       = state_q;
    mem_req_c     = 1'b0;
    mem_write_c   = 1'b0;
    lor_d_c       = 1'b0;
    ir_write_c    = 1'b0;
    pc_write_c    = 1'b0;
    branch_c      = 1'b0;
    take_c        = 1'b0;
    pc_src_c      = 2'b00;
    alu_src_a_c   = 1'b0;
    alu_src_b_c   = 2'b00;
    alu_instruc_c = 2'b00;
    reg_write_c   = 1'b0;
    reg_dst_c     = 1'b0;
    mem_reg_c     = 1'b0;
    illegal_op_c  = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req_c   = 1'b1;
        alu_src_b_c = 2'b01;
        ir_write_c  = mem_ready;
        pc_write_c  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b_c = 2'b11;
        if (instruc == OP_LW || instruc == OP_SW) state_d = S_MEMADR;
        else if (instruc == OP_RTYPE)             state_d = S_RTYPEEX;
        else if (instruc == OP_BEQ)               state_d = S_BEQEX;
        else if (instruc == OP_ADDI)              state_d = S_ADDIEX;
        else if (instruc == OP_J)                 state_d = S_JEX;
`ifdef MCTRL_BNE_EN
        else if (instruc == OP_BNE)               state_d = S_BNEEX;
`endif
        else begin
          illegal_op_c = 1'b1;
          state_d      = S_FETCH;
        end
      end
      S_MEMADR: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = (instruc == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req_c = 1'b1;
        lor_d_c   = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write_c = 1'b1;
        mem_reg_c   = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        lor_d_c     = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTYPEEX: begin
        alu_src_a_c   = 1'b1;
        alu_instruc_c = 2'b10;
        state_d       = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_write_c = 1'b1;
        reg_dst_c   = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQEX: begin
        alu_src_a_c   = 1'b1;
        alu_instruc_c = 2'b01;
        branch_c      = 1'b1;
        take_c        = zero;
        pc_src_c      = 2'b01;
        state_d       = S_FETCH;
      end
`ifdef MCTRL_BNE_EN
      S_BNEEX: begin
        alu_src_a_c   = 1'b1;
        alu_instruc_c = 2'b01;
        branch_c      = 1'b1;
        take_c        = ~zero;
        pc_src_c      = 2'b01;
        state_d       = S_FETCH;
      end
`endif
      S_ADDIEX: begin
        alu_src_a_c = 1'b1;
        alu_src_b_c = 2'b10;
        state_d     = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JEX: begin
        pc_src_c   = 2'b10;
        pc_write_c = 1'b1;
        state_d    = S_FETCH;
      end
      // Unused encodings: outputs stay at their zero defaults
      default: state_d = S_FETCH;
    endcase
  end

  // Outputs forced low while reset is held so no strobe escapes
  assign mem_req     = reset_n & mem_req_c;
  assign mem_write   = reset_n & mem_write_c;
  assign lor_d       = reset_n & lor_d_c;
  assign ir_write    = reset_n & ir_write_c;
  assign pc_write    = reset_n & pc_write_c;
  assign branch      = reset_n & branch_c;
  assign pc_en       = reset_n & (pc_write_c | (branch_c & take_c));
  assign pc_src      = reset_n ? pc_src_c : 2'b00;
  assign alu_src_a   = reset_n & alu_src_a_c;
  assign alu_src_b   = reset_n ? alu_src_b_c : 2'b00;
  assign alu_instruc = reset_n ? alu_instruc_c : 2'b00;
  assign reg_write   = reset_n & reg_write_c;
  assign reg_dst     = reset_n & reg_dst_c;
  assign mem_reg     = reset_n & mem_reg_c;
  assign illegal_op  = reset_n & illegal_op_c;
  assign state_o     = state_q;

endmodule
